muldiv_sequencer: RTL and testbench

- Sequences the external multiplier and divider units on behalf of the main control FSM and owns the HI/LO register pair.
- Accepts one mult or div request at a time and latches operands.
- Issues a one-cycle start to the selected unit, waits for its done with a watchdog, and commits results to HI/LO.
- Reports divide-by-zero and timeout as one-cycle exception pulses; also services mthi/mtlo writes.

---
 rtl/muldiv_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Sequences the external multiplier/divider on behalf of the main control FSM,
// owns the HI/LO register pair and reports divide-by-zero and watchdog faults.
module muldiv_sequencer #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mult_req,
  input  logic        div_req,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wdata,
  input  logic        mult_done,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        div_done,
  input  logic        div0,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem,
  output logic        mult_start,
  output logic        div_start,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div0_exc,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_MULT = 3'd2,
    S_WAIT_DIV  = 3'd3,
    S_COMMIT    = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

  typedef enum logic {
    CAUSE_DIV0    = 1'b0,
    CAUSE_TIMEOUT = 1'b1
  } cause_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_r, state_s;
  op_t               op_r, op_s;
  cause_t            cause_r, cause_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [31:0]       unit_a_r, unit_a_s;
  logic [31:0]       unit_b_r, unit_b_s;
  logic [31:0]       hi_r, hi_s;
  logic [31:0]       lo_r, lo_s;

  // Next-state and next-register computation for the sequencer FSM
  always_comb begin
    state_s  = state_r;
    op_s     = op_r;
    cause_s  = cause_r;
    cnt_s    = cnt_r;
    unit_a_s = unit_a_r;
    unit_b_s = unit_b_r;
    hi_s     = hi_r;
    lo_s     = lo_r;
    case (state_r)
      S_IDLE: begin
        // mthi/mtlo land even when a request is accepted; a later commit overwrites
        if (hi_wr) begin
          hi_s = wdata;
        end else begin
          hi_s = hi_r;
        end
        if (lo_wr) begin
          lo_s = wdata;
        end else begin
          lo_s = lo_r;
        end
        if (mult_req) begin
          unit_a_s = op_a;
          unit_b_s = op_b;
          op_s     = OP_MULT;
          state_s  = S_LAUNCH;
        end else if (div_req) begin
          if (op_b != 32'd0) begin
            unit_a_s = op_a;
            unit_b_s = op_b;
            op_s     = OP_DIV;
            state_s  = S_LAUNCH;
          end else begin
            cause_s = CAUSE_DIV0;
            state_s = S_FAULT;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LAUNCH: begin
        cnt_s = {CNT_W{1'b0}};
        if (op_r == OP_DIV) begin
          state_s = S_WAIT_DIV;
        end else begin
          state_s = S_WAIT_MULT;
        end
      end
      S_WAIT_MULT: begin
        if (mult_done) begin
          hi_s    = mult_hi;
          lo_s    = mult_lo;
          state_s = S_COMMIT;
        end else if (cnt_r == CNT_LAST) begin
          cause_s = CAUSE_TIMEOUT;
          state_s = S_FAULT;
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_WAIT_DIV: begin
        // a zero-divisor report outranks a simultaneous done
        if (div0) begin
          cause_s = CAUSE_DIV0;
          state_s = S_FAULT;
        end else if (div_done) begin
          lo_s    = div_quot;
          hi_s    = div_rem;
          state_s = S_COMMIT;
        end else if (cnt_r == CNT_LAST) begin
          cause_s = CAUSE_TIMEOUT;
          state_s = S_FAULT;
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_COMMIT: begin
        state_s = S_IDLE;
      end
      S_FAULT: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, operand latches, watchdog counter and HI/LO registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= S_IDLE;
      op_r     <= OP_MULT;
      cause_r  <= CAUSE_DIV0;
      cnt_r    <= {CNT_W{1'b0}};
      unit_a_r <= 32'd0;
      unit_b_r <= 32'd0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
    end else begin
      state_r  <= state_s;
      op_r     <= op_s;
      cause_r  <= cause_s;
      cnt_r    <= cnt_s;
      unit_a_r <= unit_a_s;
      unit_b_r <= unit_b_s;
      hi_r     <= hi_s;
      lo_r     <= lo_s;
    end
  end

  // Control outputs decode the state register only, so reset clears them at once
  assign mult_start  = (state_r == S_LAUNCH) && (op_r == OP_MULT);
  assign div_start   = (state_r == S_LAUNCH) && (op_r == OP_DIV);
  assign busy        = (state_r != S_IDLE);
  assign done        = (state_r == S_COMMIT);
  assign div0_exc    = (state_r == S_FAULT) && (cause_r == CAUSE_DIV0);
  assign timeout_err = (state_r == S_FAULT) && (cause_r == CAUSE_TIMEOUT);
  assign unit_a      = unit_a_r;
  assign unit_b      = unit_b_r;
  assign hi          = hi_r;
  assign lo          = lo_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: plays the multiplier/divider units and compares the
// sequencer against a transaction-level model of its documented behaviour.
module tb_muldiv_sequencer;

  localparam int TO = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        mult_req, div_req, hi_wr, lo_wr;
  logic [31:0] op_a, op_b, wdata;
  logic        mult_done, div_done, div0;
  logic [31:0] mult_hi, mult_lo, div_quot, div_rem;
  logic        mult_start, div_start, busy, done, div0_exc, timeout_err;
  logic [31:0] unit_a, unit_b, hi, lo;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_ua = 32'd0, m_ub = 32'd0;

  muldiv_sequencer #(.TIMEOUT(TO), .CNT_W(6)) dut (
    .clock(clock), .reset(reset),
    .mult_req(mult_req), .div_req(div_req), .op_a(op_a), .op_b(op_b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
    .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_done(div_done), .div0(div0), .div_quot(div_quot), .div_rem(div_rem),
    .mult_start(mult_start), .div_start(div_start),
    .unit_a(unit_a), .unit_b(unit_b), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div0_exc(div0_exc), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_outs(input string tag, input bit ms, input bit ds, input bit bsy,
                            input bit dn, input bit d0, input bit tmo);
    check_val({tag, " ctl"}, {58'd0, mult_start, div_start, busy, done, div0_exc, timeout_err},
              {58'd0, ms, ds, bsy, dn, d0, tmo});
    check_val({tag, " hilo"}, {hi, lo}, {m_hi, m_lo});
    check_val({tag, " unit"}, {unit_a, unit_b}, {m_ua, m_ub});
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    mult_req = 1'b0; div_req = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    op_a = 32'd0; op_b = 32'd0; wdata = 32'd0;
    mult_done = 1'b0; div_done = 1'b0; div0 = 1'b0;
    mult_hi = 32'd0; mult_lo = 32'd0; div_quot = 32'd0; div_rem = 32'd0;
  endtask

  // Random activity on inputs that must be ignored while busy
  task automatic drive_noise;
    mult_req  = 1'($urandom_range(0, 1));
    div_req   = 1'($urandom_range(0, 1));
    hi_wr     = 1'($urandom_range(0, 1));
    lo_wr     = 1'($urandom_range(0, 1));
    wdata     = $urandom;
    op_a      = $urandom;
    op_b      = $urandom;
    mult_done = 1'($urandom_range(0, 1));
    div_done  = 1'($urandom_range(0, 1));
    div0      = 1'($urandom_range(0, 1));
    mult_hi   = $urandom; mult_lo = $urandom;
    div_quot  = $urandom; div_rem = $urandom;
  endtask

  task automatic idle_cycle(input bit hw, input bit lw, input logic [31:0] wd, input bit noisy);
    clear_inputs();
    if (noisy) begin
      mult_done = 1'($urandom_range(0, 1));
      div_done  = 1'($urandom_range(0, 1));
      div0      = 1'($urandom_range(0, 1));
      div_quot  = $urandom; mult_lo = $urandom;
    end
    hi_wr = hw; lo_wr = lw; wdata = wd;
    step();
    if (hw) m_hi = wd;
    if (lw) m_lo = wd;
    clear_inputs();
    check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // dc: WAIT cycle (1-based) in which the unit answers, 0 = never
  task automatic do_op(input bit is_div, input bit both, input logic [31:0] a, input logic [31:0] b,
                       input int dc, input bit udiv0, input bit hw, input bit lw, input logic [31:0] wd);
    logic [63:0] prod;
    logic [31:0] rh, rl;
    clear_inputs();
    mult_req = !is_div || both; div_req = is_div || both;
    op_a = a; op_b = b; hi_wr = hw; lo_wr = lw; wdata = wd;
    step();
    if (hw) m_hi = wd;
    if (lw) m_lo = wd;
    clear_inputs();
    if (is_div && b == 32'd0) begin
      check_outs("opdiv0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      drive_noise();
      step();
      clear_inputs();
      check_outs("opdiv0 idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      return;
    end
    m_ua = a; m_ub = b;
    if (is_div) begin
      rl = a / b; rh = a % b;
    end else begin
      prod = {32'd0, a} * {32'd0, b};
      rh = prod[63:32]; rl = prod[31:0];
    end
    check_outs("launch", !is_div, is_div, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_noise();
    for (int w = 1; w <= TO; w++) begin
      step();
      check_outs($sformatf("wait%0d", w), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive_noise();
      if (is_div) begin
        div_done = (w == dc) && !udiv0;
        div0     = (w == dc) && udiv0;
        div_quot = rl; div_rem = rh;
      end else begin
        mult_done = (w == dc);
        mult_hi = rh; mult_lo = rl;
      end
      if (w == dc) break;
    end
    step();
    clear_inputs();
    if (dc == 0) begin
      check_outs("timeout", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    end else if (udiv0) begin
      check_outs("unitdiv0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    end else begin
      m_hi = rh; m_lo = rl;
      check_outs("commit", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    drive_noise();
    step();
    clear_inputs();
    check_outs("back idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    step();
    step();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();

    do_op(1'b0, 1'b0, 32'd7, 32'd6, 4, 1'b0, 1'b0, 1'b0, 32'd0);
    check_val("mult lo 42", {32'd0, lo}, 64'd42);
    do_op(1'b1, 1'b0, 32'd100, 32'd7, 3, 1'b0, 1'b0, 1'b0, 32'd0);
    check_val("div quot/rem", {hi, lo}, {32'd2, 32'd14});
    idle_cycle(1'b1, 1'b0, 32'd5, 1'b1);
    idle_cycle(1'b0, 1'b1, 32'd9, 1'b1);
    do_op(1'b1, 1'b0, 32'd55, 32'd0, 1, 1'b0, 1'b0, 1'b0, 32'd0);
    check_val("div0 keeps hilo", {hi, lo}, {32'd5, 32'd9});
    do_op(1'b0, 1'b0, 32'd3, 32'd4, 0, 1'b0, 1'b0, 1'b0, 32'd0);
    do_op(1'b0, 1'b0, 32'd3, 32'd4, TO, 1'b0, 1'b0, 1'b0, 32'd0);
    do_op(1'b1, 1'b0, 32'd9, 32'd3, TO, 1'b0, 1'b0, 1'b0, 32'd0);
    do_op(1'b1, 1'b0, 32'd9, 32'd3, 0, 1'b0, 1'b0, 1'b0, 32'd0);
    do_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b0, 1'b1, 1'b1, 32'hFFFF);
    do_op(1'b1, 1'b0, 32'd77, 32'd5, 2, 1'b1, 1'b0, 1'b0, 32'd0);
    do_op(1'b1, 1'b0, 32'd1, 32'd2, 1, 1'b0, 1'b1, 1'b0, 32'hABCD);

    // Asynchronous reset in the middle of a divide
    clear_inputs();
    div_req = 1'b1; op_a = 32'd50; op_b = 32'd3;
    step();
    clear_inputs();
    step();
    step();
    reset = 1'b0;
    #1;
    m_hi = 32'd0; m_lo = 32'd0; m_ua = 32'd0; m_ub = 32'd0;
    check_outs("midop reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    div_done = 1'b1; div_quot = 32'h1234; div_rem = 32'h5678;
    step();
    check_outs("stray done 1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    clear_inputs();
    check_outs("stray done 2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      bit          is_div, udv;
      logic [31:0] b;
      int          dc;
      is_div = 1'($urandom_range(0, 1));
      b      = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (b == 32'd0 && !is_div) b = 32'd1;
      dc     = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO);
      udv    = is_div && ($urandom_range(0, 5) == 0);
      do_op(is_div, 1'($urandom_range(0, 1)) && !is_div, $urandom, b, dc, udv,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      idle_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
